pp_carry_accum_sreg: RTL and testbench

//  Partial-product / carry accumulation shift register for the sequential Booth multiplier.

---
 rtl/pp_carry_accum_sreg.sv | 88 ++++++++
 tb/tb_pp_carry_accum_sreg.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pp_carry_accum_sreg.sv
// Partial-product / carry accumulation shift register for the sequential Booth multiplier.
// Retires SHIFT bits per step into the low half; IDLE/BUSY/DONE op control with step count.
module pp_carry_accum_sreg #(
  parameter int WIDTH = 8,
  parameter int SHIFT = 4,
  parameter int STEPS = (WIDTH + SHIFT - 1) / SHIFT,
  localparam int DW = WIDTH + SHIFT - 1,
  localparam int CW = $clog2(STEPS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               step_en,
  input  logic               signed_mode,
  input  logic [DW-1:0]      pp_din,
  input  logic [DW-1:0]      carry_din,
  output logic [WIDTH-1:0]   pp_dout,
  output logic [WIDTH-1:0]   carry_dout,
  output logic [2*WIDTH-1:0] pp_full,
  output logic [2*WIDTH-1:0] carry_full,
  output logic [CW-1:0]      step_cnt,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  state_t state;
  logic   ext;
  logic   last_step;

  assign ext       = signed_mode & pp_din[DW-1];
  assign last_step = (step_cnt == LAST);

  assign pp_dout    = pp_full[2*WIDTH-1:WIDTH];
  assign carry_dout = carry_full[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pp_full    <= '0;
      carry_full <= '0;
      step_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= BUSY;
            pp_full    <= '0;
            carry_full <= '0;
            step_cnt   <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        BUSY: begin
          // start is deliberately ignored here; only step_en advances
          if (step_en) begin
            pp_full    <= {ext, pp_din,
                           pp_full[WIDTH-1:SHIFT]};
            carry_full <= {1'b0, carry_din,
                           carry_full[WIDTH-1:SHIFT]};
            step_cnt   <= step_cnt + 1'b1;
            if (last_step) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pp_carry_accum_sreg.sv
// Bench for pp_carry_accum_sreg: directed vector table, multi-cycle
// corner sequences and a randomized run against a small model.
module tb_pp_carry_accum_sreg;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        step_en;
  logic        signed_mode;
  logic [10:0] pp_din;
  logic [10:0] carry_din;
  logic [7:0]  pp_dout;
  logic [7:0]  carry_dout;
  logic [15:0] pp_full;
  logic [15:0] carry_full;
  logic [1:0]  step_cnt;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  pp_carry_accum_sreg dut (
    .clk(clk), .rst(rst), .start(start), .step_en(step_en),
    .signed_mode(signed_mode), .pp_din(pp_din), .carry_din(carry_din),
    .pp_dout(pp_dout), .carry_dout(carry_dout), .pp_full(pp_full),
    .carry_full(carry_full), .step_cnt(step_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sm;
    logic [10:0] pp0, cy0, pp1, cy1;
    logic [15:0] epp1, ecy1, epp2, ecy2;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [15:0] epp,
                           input logic [15:0] ecy, input logic [1:0] ecnt,
                           input logic eb, input logic ed);
    chk({tag, "_pp"}, 32'(pp_full), 32'(epp));
    chk({tag, "_cy"}, 32'(carry_full), 32'(ecy));
    chk({tag, "_ppd"}, 32'(pp_dout), 32'(epp[15:8]));
    chk({tag, "_cyd"}, 32'(carry_dout), 32'(ecy[15:8]));
    chk({tag, "_cnt"}, 32'(step_cnt), 32'(ecnt));
    chk({tag, "_busy"}, 32'(busy), 32'(eb));
    chk({tag, "_done"}, 32'(done), 32'(ed));
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_step(input logic [10:0] p, input logic [10:0] c);
    pp_din = p;
    carry_din = c;
    step_en = 1'b1;
    tick();
    step_en = 1'b0;
  endtask

  logic [15:0] m_pp, m_cy, h_pp, h_cy;
  logic [1:0]  h_cnt;

  initial begin
    vecs[0] = '{1'b0, 11'h7FF, 11'h000, 11'h012, 11'h000,
                16'h7FF0, 16'h0000, 16'h012F, 16'h0000};
    vecs[1] = '{1'b1, 11'h400, 11'h7FF, 11'h000, 11'h000,
                16'hC000, 16'h7FF0, 16'h0000, 16'h000F};
    vecs[2] = '{1'b0, 11'h400, 11'h001, 11'h5A5, 11'h3C3,
                16'h4000, 16'h0010, 16'h5A50, 16'h3C31};
    vecs[3] = '{1'b1, 11'h123, 11'h0AB, 11'h7FF, 11'h555,
                16'h1230, 16'h0AB0, 16'hFFF3, 16'h555B};
    vecs[4] = '{1'b1, 11'h6BC, 11'h001, 11'h081, 11'h000,
                16'hEBC0, 16'h0010, 16'h081C, 16'h0001};

    rst = 1'b1; start = 1'b0; step_en = 1'b0; signed_mode = 1'b0;
    pp_din = '0; carry_din = '0;
    #12;
    chk_state("reset", 16'h0, 16'h0, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_state("idle", 16'h0, 16'h0, 2'd0, 1'b0, 1'b0);

    // step_en in IDLE is ignored
    do_step(11'h7FF, 11'h7FF);
    chk_state("idle_step", 16'h0, 16'h0, 2'd0, 1'b0, 1'b0);

    // directed table
    for (int i = 0; i < 5; i++) begin
      signed_mode = vecs[i].sm;
      do_start();
      chk_state($sformatf("v%0d_start", i), 16'h0, 16'h0, 2'd0, 1'b1, 1'b0);
      do_step(vecs[i].pp0, vecs[i].cy0);
      chk_state($sformatf("v%0d_s1", i), vecs[i].epp1, vecs[i].ecy1,
                2'd1, 1'b1, 1'b0);
      do_step(vecs[i].pp1, vecs[i].cy1);
      chk_state($sformatf("v%0d_s2", i), vecs[i].epp2, vecs[i].ecy2,
                2'd2, 1'b0, 1'b1);
    end

    // DONE holds; step_en ignored
    do_step(11'h555, 11'h2AA);
    chk_state("done_hold", 16'h081C, 16'h0001, 2'd2, 1'b0, 1'b1);

    // start in DONE with step_en high: cleared, step ignored
    pp_din = 11'h7FF; carry_din = 11'h7FF; step_en = 1'b1;
    do_start();
    step_en = 1'b0;
    chk_state("restart", 16'h0, 16'h0, 2'd0, 1'b1, 1'b0);

    // stall between steps, with start pulses ignored while BUSY
    signed_mode = 1'b0;
    do_step(11'h7FF, 11'h7FF);
    chk_state("st_s1", 16'h7FF0, 16'h7FF0, 2'd1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      pp_din = 11'($urandom);
      carry_din = 11'($urandom);
      start = (k == 2);
      tick();
      chk_state($sformatf("stall%0d", k), 16'h7FF0, 16'h7FF0,
                2'd1, 1'b1, 1'b0);
    end
    start = 1'b0;
    do_step(11'h012, 11'h000);
    chk_state("st_s2", 16'h012F, 16'h000F, 2'd2, 1'b0, 1'b1);

    // async reset mid-BUSY, checked before the next edge
    do_start();
    do_step(11'h7FF, 11'h7FF);
    chk("pre_rst_cnt", 32'(step_cnt), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_state("midrst", 16'h0, 16'h0, 2'd0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    tick();
    chk_state("post_rst", 16'h0, 16'h0, 2'd0, 1'b0, 1'b0);

    // randomized regression against a reference model
    for (int op = 0; op < 4000; op++) begin
      signed_mode = 1'($urandom);
      do_start();
      m_pp = '0;
      m_cy = '0;
      for (int s = 0; s < 2; s++) begin
        h_pp = pp_full;
        h_cy = carry_full;
        h_cnt = step_cnt;
        for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
          pp_din = 11'($urandom);
          tick();
        end
        if (pp_full !== h_pp || carry_full !== h_cy || step_cnt !== h_cnt)
          chk("rand_stall", {pp_full, carry_full}, {h_pp, h_cy});
        pp_din = 11'($urandom);
        carry_din = 11'($urandom);
        m_pp = {signed_mode & pp_din[10], pp_din, m_pp[7:4]};
        m_cy = {1'b0, carry_din, m_cy[7:4]};
        do_step(pp_din, carry_din);
      end
      if (op % 400 == 0 || pp_full !== m_pp || carry_full !== m_cy ||
          done !== 1'b1 || step_cnt !== 2'd2) begin
        chk($sformatf("rand%0d_pp", op), 32'(pp_full), 32'(m_pp));
        chk($sformatf("rand%0d_cy", op), 32'(carry_full), 32'(m_cy));
        chk($sformatf("rand%0d_done", op),
            {30'd0, step_cnt}, 32'({1'b1, 1'b0}) & {30'd0, done, 1'b0}
            | 32'd2);
        chk($sformatf("rand%0d_dflag", op), 32'(done), 32'd1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
